// File: rtl/adder_pkg.sv
// Shared widths and defaults for the board-level switch adder.
package adder_pkg;
  localparam int OPERAND_W        = 4;
  localparam int SUM_W            = OPERAND_W + 1;
  localparam int DEF_SYNC_STAGES  = 2;
endpackage

// File: rtl/adder_full_adder.sv
// One-bit full adder, purely combinational; zero latency, no flow control.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);
  logic w_p;

  assign w_p    = i_a ^ i_b;
  assign o_s    = w_p ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & w_p);
endmodule

// File: rtl/adder_top.sv
// Synchronizes switch/button operands and registers their ripple-carry sum onto the LEDs.
// Latency SYNC_STAGES+1 flops (input stable before edge k shows after edge k+SYNC_STAGES); no backpressure.
module adder_top
  import adder_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Sw0,
  input  logic             Sw1,
  input  logic             Sw2,
  input  logic             Sw3,
  input  logic             Sw4,
  input  logic             Sw5,
  input  logic             Sw6,
  input  logic             Sw7,
  input  logic             Btn0,
  output logic [SUM_W-1:0] Output
);
  localparam int NUM_IN = 2 * OPERAND_W + 1;

  logic [NUM_IN-1:0]    w_raw;
  logic [NUM_IN-1:0]    w_sync;
  logic [OPERAND_W-1:0] w_a;
  logic [OPERAND_W-1:0] w_b;
  logic [OPERAND_W-1:0] w_s;
  logic [OPERAND_W:0]   w_carry;
  logic [SUM_W-1:0]     w_sum;

  assign w_raw = {Btn0, Sw7, Sw6, Sw5, Sw4, Sw3, Sw2, Sw1, Sw0};

  // Each input gets its own chain so no bit shares metastability exposure with another.
  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] r_chain;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_chain <= '0;
      end else begin
        r_chain <= {r_chain[SYNC_STAGES-2:0], w_raw[gi]};
      end
    end

    assign w_sync[gi] = r_chain[SYNC_STAGES-1];
  end

  assign w_a        = w_sync[OPERAND_W-1:0];
  assign w_b        = w_sync[2*OPERAND_W-1:OPERAND_W];
  assign w_carry[0] = w_sync[NUM_IN-1];

  for (genvar gb = 0; gb < OPERAND_W; gb++) begin : g_ripple
    full_adder u_fa (
      .i_a    (w_a[gb]),
      .i_b    (w_b[gb]),
      .i_cin  (w_carry[gb]),
      .o_s    (w_s[gb]),
      .o_cout (w_carry[gb+1])
    );
  end

  assign w_sum = {w_carry[OPERAND_W], w_s};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Output <= '0;
    end else begin
      Output <= w_sum;
    end
  end
endmodule

// File: tb/tb_adder_top.sv
// Directed and randomized checks of adder_top against an arithmetic reference model.
module tb_adder_top;
  logic       clk;
  logic       rst;
  logic       Sw0, Sw1, Sw2, Sw3, Sw4, Sw5, Sw6, Sw7;
  logic       Btn0;
  logic [4:0] Output;

  int n_checks;
  int n_fail;

  adder_top u_dut (
    .clk    (clk),
    .rst    (rst),
    .Sw0    (Sw0),
    .Sw1    (Sw1),
    .Sw2    (Sw2),
    .Sw3    (Sw3),
    .Sw4    (Sw4),
    .Sw5    (Sw5),
    .Sw6    (Sw6),
    .Sw7    (Sw7),
    .Btn0   (Btn0),
    .Output (Output)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [4:0] model_sum(input int a, input int b, input int c);
    int total;
    total = a + b + c;
    return total[4:0];
  endfunction

  task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic c);
    {Sw3, Sw2, Sw1, Sw0} = a;
    {Sw7, Sw6, Sw5, Sw4} = b;
    Btn0 = c;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    n_checks = 0;
    n_fail   = 0;

    set_in(4'hF, 4'hF, 1'b1);
    rst = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_immediate", Output, 5'b00000);
    tick(2);
    check("reset_held", Output, 5'b00000);
    rst = 1'b0;
    tick(2);
    check("release_not_yet", Output, 5'b00000);
    tick(1);
    check("release_max", Output, model_sum(15, 15, 1));

    set_in(4'd0, 4'd0, 1'b0);
    tick(4);
    check("all_zero", Output, 5'b00000);
    Sw1 = 1'b1;
    tick(2);
    check("sw1_not_before", Output, 5'b00000);
    tick(1);
    check("sw1_latency", Output, 5'b00010);

    set_in(4'd10, 4'd9, 1'b0);
    tick(4);
    check("build_19", Output, 5'b10011);
    Btn0 = 1'b1;
    tick(4);
    check("build_20_cin", Output, 5'b10100);

    set_in(4'b1111, 4'b0001, 1'b0);
    tick(4);
    check("ripple_16", Output, 5'b10000);
    set_in(4'b0111, 4'b0001, 1'b0);
    tick(4);
    check("ripple_8", Output, 5'b01000);

    set_in(4'd10, 4'd9, 1'b1);
    tick(4);
    check("pre_midreset_20", Output, model_sum(10, 9, 1));
    #3 rst = 1'b1;
    #1 check("midreset_clear", Output, 5'b00000);
    #1 rst = 1'b0;
    tick(2);
    check("midreset_rebuild_early", Output, 5'b00000);
    tick(1);
    check("midreset_rebuild_20", Output, model_sum(10, 9, 1));

    for (int i = 0; i < 40; i++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rc = 1'($urandom_range(0, 1));
      set_in(ra, rb, rc);
      tick(3);
      check("random_latency", Output, model_sum(int'(ra), int'(rb), int'(rc)));
      tick(1);
      check("random_hold", Output, model_sum(int'(ra), int'(rb), int'(rc)));
    end

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        for (int c = 0; c < 2; c++) begin
          set_in(4'(a), 4'(b), 1'(c));
          tick(4);
          check("sweep", Output, model_sum(a, b, c));
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
